ps2_key_fifo: RTL and testbench

Keyboard event decoder and buffer. It sits between the PS/2 byte receiver (`ps2_ver2`) and `MIO_BUS`. Raw scan-code bytes are folded into 10-bit key events {break, extended, code}. Each event is queued in a small FIFO so that no key is lost while the CPU is polling. The CPU sees the head event on the bus, and each pop (a bus read strobe) consumes one event.

---
 rtl/ps2_pkg.sv | 29 ++
 rtl/key_fifo.sv | 83 ++++++++
 rtl/ps2_key_fifo.sv | 133 +++++++++++++
 tb/tb_ps2_key_fifo.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 scan-code constants, decoder state encoding and the discard-list helper.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT        = 8'hE0;
  localparam logic [7:0] PS2_BRK        = 8'hF0;
  localparam logic [7:0] PS2_PAUSE      = 8'hE1;
  localparam logic [7:0] PS2_FAKE_SHIFT = 8'h12;

  localparam logic [9:0] PAUSE_EVT  = 10'h1E1;
  // Pause/Break sends E1 followed by seven more bytes that carry no information.
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    EXT     = 3'd1,
    BRK     = 3'd2,
    EXT_BRK = 3'd3,
    PAUSE   = 3'd4
  } ps2_state_e;

  // Keyboard status/acknowledge bytes that never represent a key.
  function automatic logic is_discard(input logic [7:0] b);
    case (b)
      8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: return 1'b1;
      default:                                  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/key_fifo.sv
// Generic show-ahead circular FIFO: head word is combinational, count/flags come
// from a registered occupancy counter, overflow is sticky until reset or flush.
module key_fifo #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic             o_full,
  output logic [PTR_W:0]   o_count,
  output logic             o_overflow
);

  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             r_overflow;

  logic w_empty;
  logic w_full;
  logic w_do_push;
  logic w_do_pop;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == FULL_CNT);
  assign w_do_pop  = i_pop & ~w_empty;
  // A pop in the same cycle frees the slot, so a push while full still lands.
  assign w_do_push = i_push & (~w_full | w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (i_flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
      if (i_push && w_full && !w_do_pop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign o_data     = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_empty    = w_empty;
  assign o_full     = w_full;
  assign o_count    = r_count;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/ps2_key_fifo.sv
// PS/2 scan-code decoder: folds prefix bytes into {break, extended, code} events
// and queues them in a show-ahead FIFO for the CPU to poll.
module ps2_key_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [7:0]     ps2_data,
  input  logic           ps2_ready,
  input  logic           rd_en,
  input  logic           flush,
  output logic [9:0]     key_out,
  output logic           empty,
  output logic           full,
  output logic [PTR_W:0] count,
  output logic           overflow
);

  logic       r_ready_q;
  ps2_state_e r_state;
  logic [2:0] r_skip_cnt;
  logic       r_push;
  logic [9:0] r_push_data;

  logic       w_stb;
  ps2_state_e w_state_next;
  logic [2:0] w_skip_next;
  logic       w_push_next;
  logic [9:0] w_push_data_next;

  assign w_stb = ps2_ready & ~r_ready_q;

  always_comb begin
    w_state_next     = r_state;
    w_skip_next      = r_skip_cnt;
    w_push_next      = 1'b0;
    w_push_data_next = '0;
    if (w_stb) begin
      case (r_state)
        IDLE: begin
          if (ps2_data == PS2_EXT) begin
            w_state_next = EXT;
          end else if (ps2_data == PS2_BRK) begin
            w_state_next = BRK;
          end else if (ps2_data == PS2_PAUSE) begin
            w_state_next = PAUSE;
            w_skip_next  = PAUSE_SKIP;
          end else if (!is_discard(ps2_data)) begin
            w_push_next      = 1'b1;
            w_push_data_next = {2'b00, ps2_data};
          end
        end
        EXT: begin
          if (ps2_data == PS2_BRK) begin
            w_state_next = EXT_BRK;
          end else begin
            w_state_next = IDLE;
            // E0 12 / E0 E0 are the keyboard's fake-shift noise, not keys.
            if (ps2_data != PS2_FAKE_SHIFT && ps2_data != PS2_EXT) begin
              w_push_next      = 1'b1;
              w_push_data_next = {2'b01, ps2_data};
            end
          end
        end
        BRK: begin
          w_state_next     = IDLE;
          w_push_next      = 1'b1;
          w_push_data_next = {2'b10, ps2_data};
        end
        EXT_BRK: begin
          w_state_next     = IDLE;
          w_push_next      = 1'b1;
          w_push_data_next = {2'b11, ps2_data};
        end
        PAUSE: begin
          w_skip_next = r_skip_cnt - 3'd1;
          if (r_skip_cnt == 3'd1) begin
            w_state_next     = IDLE;
            w_push_next      = 1'b1;
            w_push_data_next = PAUSE_EVT;
          end
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  // Decoded events are registered, so the FIFO write lands one cycle after the strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ready_q   <= 1'b0;
      r_state     <= IDLE;
      r_skip_cnt  <= '0;
      r_push      <= 1'b0;
      r_push_data <= '0;
    end else begin
      r_ready_q <= ps2_ready;
      if (flush) begin
        r_state     <= IDLE;
        r_skip_cnt  <= '0;
        r_push      <= 1'b0;
        r_push_data <= '0;
      end else begin
        r_state     <= w_state_next;
        r_skip_cnt  <= w_skip_next;
        r_push      <= w_push_next;
        r_push_data <= w_push_data_next;
      end
    end
  end

  key_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .WIDTH (10)
  ) u_key_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (r_push),
    .i_data     (r_push_data),
    .i_pop      (rd_en),
    .i_flush    (flush),
    .o_data     (key_out),
    .o_empty    (empty),
    .o_full     (full),
    .o_count    (count),
    .o_overflow (overflow)
  );

endmodule

// File: tb/tb_ps2_key_fifo.sv
// Directed bench for ps2_key_fifo: scan-code sequences in, queued key events out.
module tb_ps2_key_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ps2_data;
  logic       ps2_ready;
  logic       rd_en;
  logic       flush;
  logic [9:0] key_out;
  logic       empty;
  logic       full;
  logic [3:0] count;
  logic       overflow;

  int checks   = 0;
  int failures = 0;

  ps2_key_fifo #(.DEPTH(8), .PTR_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_data  (ps2_data),
    .ps2_ready (ps2_ready),
    .rd_en     (rd_en),
    .flush     (flush),
    .key_out   (key_out),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One byte: ready rises, strobe seen at the next edge, FIFO write at the one after.
  task automatic send_byte(input logic [7:0] b, input logic pop_at_write);
    ps2_data  = b;
    ps2_ready = 1'b1;
    tick();
    rd_en = pop_at_write;
    tick();
    rd_en     = 1'b0;
    ps2_ready = 1'b0;
    tick();
    $display("rx byte %02h pop=%0d -> count=%0d head=%03h", b, pop_at_write, count, key_out);
  endtask

  task automatic pop();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    $display("pop -> count=%0d head=%03h", count, key_out);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    checks++; if (key_out !== 10'h000) begin failures++; $display("FAIL rst_key_out got=%h exp=%h", key_out, 10'h000); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL rst_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL rst_full got=%b exp=0", full); end
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", count); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rst_overflow got=%b exp=0", overflow); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_make_break();
    send_byte(8'h1C, 1'b0);
    checks++; if (key_out !== 10'h01C) begin failures++; $display("FAIL mk_head got=%h exp=%h", key_out, 10'h01C); end
    checks++; if (empty !== 1'b0) begin failures++; $display("FAIL mk_empty got=%b exp=0", empty); end
    send_byte(8'hF0, 1'b0);
    send_byte(8'h1C, 1'b0);
    checks++; if (count !== 4'd2) begin failures++; $display("FAIL mk_count got=%0d exp=2", count); end
    pop();
    checks++; if (key_out !== 10'h21C) begin failures++; $display("FAIL brk_head got=%h exp=%h", key_out, 10'h21C); end
    pop();
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL mk_drained got=%b exp=1", empty); end
    checks++; if (key_out !== 10'h000) begin failures++; $display("FAIL mk_empty_key got=%h exp=0", key_out); end
  endtask

  task automatic test_extended();
    send_byte(8'hE0, 1'b0);
    send_byte(8'h75, 1'b0);
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h75, 1'b0);
    checks++; if (count !== 4'd2) begin failures++; $display("FAIL ext_count got=%0d exp=2", count); end
    checks++; if (key_out !== 10'h175) begin failures++; $display("FAIL ext_make got=%h exp=%h", key_out, 10'h175); end
    pop();
    checks++; if (key_out !== 10'h375) begin failures++; $display("FAIL ext_break got=%h exp=%h", key_out, 10'h375); end
    pop();
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL ext_drained got=%b exp=1", empty); end
  endtask

  task automatic test_pause_discard();
    logic [7:0] seq [8];
    seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    for (int i = 0; i < 8; i++) begin
      send_byte(seq[i], 1'b0);
      if (i == 6) begin
        checks++; if (count !== 4'd0) begin failures++; $display("FAIL pause_early got=%0d exp=0", count); end
      end
    end
    checks++; if (count !== 4'd1) begin failures++; $display("FAIL pause_count got=%0d exp=1", count); end
    checks++; if (key_out !== 10'h1E1) begin failures++; $display("FAIL pause_evt got=%h exp=%h", key_out, 10'h1E1); end
    send_byte(8'hAA, 1'b0);
    send_byte(8'hFA, 1'b0);
    checks++; if (count !== 4'd1) begin failures++; $display("FAIL discard_count got=%0d exp=1", count); end
    pop();
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL pause_drained got=%b exp=1", empty); end
  endtask

  task automatic test_full_overflow();
    for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b0);
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL full_at8 got=%b exp=1", full); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_at8 got=%b exp=0", overflow); end
    send_byte(8'h09, 1'b0);
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_at9 got=%b exp=1", overflow); end
    checks++; if (count !== 4'd8) begin failures++; $display("FAIL count_at9 got=%0d exp=8", count); end
    for (int i = 1; i <= 8; i++) begin
      checks++; if (key_out !== 10'(i)) begin failures++; $display("FAIL order_%0d got=%h exp=%h", i, key_out, 10'(i)); end
      pop();
    end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL full_drained got=%b exp=1", empty); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    for (int i = 0; i < 8; i++) send_byte(8'h11 + 8'(i), 1'b0);
    send_byte(8'h19, 1'b1);
    checks++; if (count !== 4'd8) begin failures++; $display("FAIL pushpop_count got=%0d exp=8", count); end
    checks++; if (key_out !== 10'h012) begin failures++; $display("FAIL pushpop_head got=%h exp=%h", key_out, 10'h012); end
    for (int i = 0; i < 7; i++) pop();
    checks++; if (key_out !== 10'h019) begin failures++; $display("FAIL pushpop_tail got=%h exp=%h", key_out, 10'h019); end
    pop();
  endtask

  task automatic test_held_ready();
    ps2_data  = 8'h2A;
    ps2_ready = 1'b1;
    repeat (50) tick();
    ps2_ready = 1'b0;
    tick();
    checks++; if (count !== 4'd1) begin failures++; $display("FAIL held_count got=%0d exp=1", count); end
    checks++; if (key_out !== 10'h02A) begin failures++; $display("FAIL held_key got=%h exp=%h", key_out, 10'h02A); end
    pop();
    pop();
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL empty_pop_count got=%0d exp=0", count); end
    send_byte(8'h3B, 1'b0);
    checks++; if (key_out !== 10'h03B) begin failures++; $display("FAIL empty_pop_ptr got=%h exp=%h", key_out, 10'h03B); end
    pop();
  endtask

  task automatic test_flush_reset();
    for (int i = 0; i < 9; i++) send_byte(8'h40 + 8'(i), 1'b0);
    send_byte(8'hE0, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    $display("flush -> count=%0d overflow=%0d", count, overflow);
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL flush_ovf got=%b exp=0", overflow); end
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL flush_count got=%0d exp=0", count); end
    send_byte(8'h75, 1'b0);
    checks++; if (key_out !== 10'h075) begin failures++; $display("FAIL flush_fsm got=%h exp=%h", key_out, 10'h075); end
    pop();
    send_byte(8'hE0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    $display("reset -> count=%0d", count);
    send_byte(8'h75, 1'b0);
    checks++; if (key_out !== 10'h075) begin failures++; $display("FAIL rst_fsm got=%h exp=%h", key_out, 10'h075); end
    checks++; if (count !== 4'd1) begin failures++; $display("FAIL rst_fsm_count got=%0d exp=1", count); end
  endtask

  initial begin
    ps2_data  = 8'h00;
    ps2_ready = 1'b0;
    rd_en     = 1'b0;
    flush     = 1'b0;
    rst       = 1'b1;
    tick();
    test_reset();
    test_make_break();
    test_extended();
    test_pause_discard();
    test_full_overflow();
    test_held_ready();
    test_flush_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before end of test sequence");
    $fatal(1, "watchdog");
  end

endmodule
